// File: rtl/seq_mult_core.sv
// Iterative unsigned shift-and-add multiplier with an input FIFO; one product
// per DATA_WIDTH+1 cycles, sticky overflow when a pair arrives at a full FIFO.
module seq_mult_core #(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          valid_in,
  input  logic [DATA_WIDTH-1:0]         a,
  input  logic [DATA_WIDTH-1:0]         b,
  output logic                          valid_out,
  output logic [RESULT_WIDTH-1:0]       out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  if (RESULT_WIDTH != 2 * DATA_WIDTH) begin : g_bad_result_width
    $error("seq_mult_core: RESULT_WIDTH must equal 2*DATA_WIDTH");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("seq_mult_core: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic {IDLE, CALC} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   mem_a [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   mem_b [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic [RESULT_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0]   mplier_q, mplier_d;
  logic [RESULT_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [RESULT_WIDTH-1:0] out_q, out_d;
  logic                    valid_q, valid_d;
  logic                    ovf_q, ovf_d;
  logic                    push, pop;
  logic [RESULT_WIDTH-1:0] acc_sum;

  always_comb begin
    // Full is judged on the registered level, so a pop on the same edge
    // never frees room for a concurrent push.
    push    = valid_in && (level_q != LW'(FIFO_DEPTH));
    pop     = (state_q == IDLE) && (level_q != '0);
    acc_sum = mplier_q[0] ? acc_q + mcand_q : acc_q;

    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    valid_d  = 1'b0;
    ovf_d    = ovf_q | (valid_in & ~push);
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    case (state_q)
      IDLE: begin
        if (pop) begin
          mcand_d  = RESULT_WIDTH'(mem_a[rd_ptr_q]);
          mplier_d = mem_b[rd_ptr_q];
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          out_d   = acc_sum;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_q] <= a;
      mem_b[wr_ptr_q] <= b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign valid_out  = valid_q;
  assign out        = out_q;
  assign busy       = (level_q != '0) || (state_q == CALC);
  assign fifo_level = level_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_seq_mult_core.sv
// Bench for seq_mult_core: queue-based reference model of the FIFO and the
// fixed-latency multiplier, checked every cycle plus directed scenario checks.
module tb_seq_mult_core;
  localparam int DW = 8;
  localparam int RW = 16;
  localparam int FD = 4;
  localparam int LW = $clog2(FD) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in;
  logic [DW-1:0] a, b;
  logic          valid_out;
  logic [RW-1:0] out;
  logic          busy;
  logic [LW-1:0] fifo_level;
  logic          overflow;

  seq_mult_core #(.DATA_WIDTH(DW), .RESULT_WIDTH(RW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .a(a), .b(b),
    .valid_out(valid_out), .out(out), .busy(busy),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending products, countdown of the running multiply.
  int unsigned pend[$];
  int unsigned cur_m;
  int          timer_m;
  bit          vo_m, ov_m;
  int unsigned out_m;

  // Observation log for scenario-level checks.
  int          cyc;
  int          pulses;
  int unsigned outs[$];
  int          pulse_cyc[$];
  int          max_lvl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    timer_m = 0;
    vo_m    = 1'b0;
    ov_m    = 1'b0;
    out_m   = 0;
  endtask

  task automatic model_edge(input bit v, input logic [DW-1:0] aa, input logic [DW-1:0] bb);
    bit full;
    full = (pend.size() == FD);
    vo_m = 1'b0;
    if (timer_m > 0) begin
      timer_m--;
      if (timer_m == 0) begin
        vo_m  = 1'b1;
        out_m = cur_m;
      end
    end else if (pend.size() > 0) begin
      cur_m   = pend.pop_front();
      timer_m = DW;
    end
    if (v) begin
      if (full) ov_m = 1'b1;
      else pend.push_back(int'(aa) * int'(bb));
    end
  endtask

  task automatic check_all();
    chk("valid_out", 32'(valid_out), 32'(vo_m));
    chk("out", 32'(out), out_m);
    chk("busy", 32'(busy), (pend.size() > 0 || timer_m > 0) ? 32'd1 : 32'd0);
    chk("fifo_level", 32'(fifo_level), pend.size());
    chk("overflow", 32'(overflow), 32'(ov_m));
    if (valid_out === 1'b1) begin
      pulses++;
      outs.push_back(32'(out));
      pulse_cyc.push_back(cyc);
    end
    if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
  endtask

  task automatic cycle(input bit v, input logic [DW-1:0] aa, input logic [DW-1:0] bb);
    valid_in = v;
    a        = aa;
    b        = bb;
    @(posedge clk);
    cyc++;
    model_edge(v, aa, bb);
    #1;
    valid_in = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, '0, '0);
  endtask

  task automatic clear_log();
    pulses = 0;
    outs.delete();
    pulse_cyc.delete();
    max_lvl = 0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((pend.size() > 0 || timer_m > 0) && k < 200) begin
      cycle(1'b0, '0, '0);
      k++;
    end
    chk("drain_bound", (k < 200) ? 32'd1 : 32'd0, 32'd1);
    idle(2);
  endtask

  initial begin
    int unsigned ca[4];
    int unsigned cb[4];
    int unsigned ce[4];
    ca = '{255, 0, 1, 128};
    cb = '{255, 200, 255, 2};
    ce = '{65025, 0, 255, 256};

    rst_n = 1'b0; valid_in = 1'b0; a = '0; b = '0;
    cyc = 0;
    model_reset();
    clear_log();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // Single multiply: pulse in the cycle after E9.
    clear_log();
    cycle(1'b1, 8'd13, 8'd11);
    idle(8);
    chk("single_early", 32'(valid_out), 32'd0);
    idle(1);
    chk("single_pulse", 32'(valid_out), 32'd1);
    chk("single_out", 32'(out), 32'd143);
    idle(5);
    chk("single_hold", 32'(out), 32'd143);
    chk("single_busy", 32'(busy), 32'd0);
    chk("single_ovf", 32'(overflow), 32'd0);
    chk("single_npulse", pulses, 32'd1);

    // Corner operands, one at a time.
    for (int i = 0; i < 4; i++) begin
      clear_log();
      cycle(1'b1, DW'(ca[i]), DW'(cb[i]));
      drain();
      chk("corner_npulse", pulses, 32'd1);
      chk("corner_out", (outs.size() > 0) ? outs[0] : 32'hDEAD, ce[i]);
    end

    // Overflow burst: six back-to-back pairs, sixth dropped.
    clear_log();
    for (int i = 0; i < 6; i++) cycle(1'b1, DW'(i + 1), DW'(i + 2));
    chk("burst_ovf_set", 32'(overflow), 32'd1);
    drain();
    chk("burst_npulse", pulses, 32'd5);
    for (int i = 0; i < 5; i++)
      chk("burst_out", (outs.size() > i) ? outs[i] : 32'hDEAD, (i + 1) * (i + 2));
    for (int i = 0; i < 4; i++)
      chk("burst_spacing",
          (pulse_cyc.size() > i + 1) ? 32'(pulse_cyc[i+1] - pulse_cyc[i]) : 32'hDEAD, 32'd9);
    chk("burst_max_level", max_lvl, 32'd4);
    chk("burst_ovf_sticky", 32'(overflow), 32'd1);

    // Asynchronous reset in the middle of a calculation.
    clear_log();
    cycle(1'b1, 8'd200, 8'd3);
    idle(4);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_async_ovf", 32'(overflow), 32'd0);
    repeat (2) begin
      @(posedge clk);
      cyc++;
      #1;
      check_all();
    end
    rst_n = 1'b1;
    idle(12);
    chk("rst_no_pulse", pulses, 32'd0);
    clear_log();
    cycle(1'b1, 8'd7, 8'd9);
    idle(9);
    chk("rst_after_pulse", 32'(valid_out), 32'd1);
    chk("rst_after_out", 32'(out), 32'd63);
    drain();

    // Overlap: new pair presented during the previous product's pulse.
    clear_log();
    cycle(1'b1, 8'd10, 8'd10);
    idle(9);
    chk("ovl_pulse", 32'(valid_out), 32'd1);
    chk("ovl_first", 32'(out), 32'd100);
    cycle(1'b1, 8'd5, 8'd5);
    drain();
    chk("ovl_npulse", pulses, 32'd2);
    chk("ovl_second", (outs.size() > 1) ? outs[1] : 32'hDEAD, 32'd25);
    chk("ovl_ovf", 32'(overflow), 32'd0);

    // Random traffic against the model, including occasional overflow.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) == 0, DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
